// File: rtl/me_pkg.sv
// Shared widths, partition counts and FSM encoding for the motion-estimation
// best-MV tracking stage.
package me_pkg;

    // SAD field widths per partition shape
    localparam int unsigned W4X8   = 13;
    localparam int unsigned W8X4   = 13;
    localparam int unsigned W8X8   = 14;
    localparam int unsigned W8X16  = 15;
    localparam int unsigned W16X8  = 15;
    localparam int unsigned W16X16 = 16;
    localparam int unsigned W32X32 = 18;

    // Number of partitions of each shape inside a 32x32 block
    localparam int unsigned N4X8   = 32;
    localparam int unsigned N8X4   = 32;
    localparam int unsigned N8X8   = 16;
    localparam int unsigned N8X16  = 8;
    localparam int unsigned N16X8  = 8;
    localparam int unsigned N16X16 = 4;
    localparam int unsigned N32X32 = 1;

    // Motion vector packing: {row, col}
    localparam int unsigned MV_W  = 12;
    localparam int unsigned COL_W = 5;
    localparam int unsigned ROW_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sad_min_cell.sv
// Running-minimum tracker for one partition: keeps the smallest SAD seen
// since the last clear and the MV of the first candidate that reached it.
module sad_min_cell
    import me_pkg::*;
#(
    parameter int unsigned SAD_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [SAD_W-1:0] sad,
    input  logic [MV_W-1:0]  mv,
    output logic [SAD_W-1:0] min_sad,
    output logic [MV_W-1:0]  best_mv
);

    // Clear to all-ones/zero, otherwise take strictly smaller candidates only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_sad <= '1;
            best_mv <= '0;
        end else if (clear) begin
            min_sad <= '1;
            best_mv <= '0;
        end else if (en && (sad < min_sad)) begin
            min_sad <= sad;
            best_mv <= mv;
        end
    end

endmodule

// File: rtl/basic_layer_best_mv.sv
// Best-MV selection over a full search window: one sad_min_cell per
// partition, sequenced by a small IDLE/SEARCH/DONE controller.
module basic_layer_best_mv
    import me_pkg::*;
#(
    parameter int unsigned LAST_COL = 31,
    parameter int unsigned LAST_ROW = 63
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        search_start,
    input  logic                        sad_valid,
    input  logic [N4X8*W4X8-1:0]        SAD4x8,
    input  logic [N8X4*W8X4-1:0]        SAD8x4,
    input  logic [N8X8*W8X8-1:0]        SAD8x8,
    input  logic [N8X16*W8X16-1:0]      SAD8x16,
    input  logic [N16X8*W16X8-1:0]      SAD16x8,
    input  logic [N16X16*W16X16-1:0]    SAD16x16,
    input  logic [N32X32*W32X32-1:0]    SAD32x32,
    input  logic [COL_W-1:0]            search_column_count,
    input  logic [ROW_W-1:0]            search_row_count,
    output logic [N4X8*W4X8-1:0]        min4x8,
    output logic [N8X4*W8X4-1:0]        min8x4,
    output logic [N8X8*W8X8-1:0]        min8x8,
    output logic [N8X16*W8X16-1:0]      min8x16,
    output logic [N16X8*W16X8-1:0]      min16x8,
    output logic [N16X16*W16X16-1:0]    min16x16,
    output logic [N32X32*W32X32-1:0]    min32x32,
    output logic [N4X8*MV_W-1:0]        mv4x8,
    output logic [N8X4*MV_W-1:0]        mv8x4,
    output logic [N8X8*MV_W-1:0]        mv8x8,
    output logic [N8X16*MV_W-1:0]       mv8x16,
    output logic [N16X8*MV_W-1:0]       mv16x8,
    output logic [N16X16*MV_W-1:0]      mv16x16,
    output logic [N32X32*MV_W-1:0]      mv32x32,
    output logic                        busy,
    output logic                        result_valid
);

    state_t            state, state_next;
    logic              last_cand;
    logic              cand_en;
    logic [MV_W-1:0]   cand_mv;

    assign last_cand = (search_column_count == COL_W'(LAST_COL)) &&
                       (search_row_count    == ROW_W'(LAST_ROW));
    assign cand_mv   = {search_row_count, search_column_count};
    // A start in the same cycle as a candidate wins; the candidate is dropped
    assign cand_en   = (state == SEARCH) && sad_valid && !search_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and status outputs; search_start restarts from any state
    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE:   ;
            SEARCH: begin
                busy = 1'b1;
                if (sad_valid && last_cand) state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (search_start) state_next = SEARCH;
    end

    for (genvar i = 0; i < N4X8; i++) begin : g_4x8
        sad_min_cell #(.SAD_W(W4X8)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD4x8[W4X8*i +: W4X8]),
            .mv      (cand_mv),
            .min_sad (min4x8[W4X8*i +: W4X8]),
            .best_mv (mv4x8[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N8X4; i++) begin : g_8x4
        sad_min_cell #(.SAD_W(W8X4)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD8x4[W8X4*i +: W8X4]),
            .mv      (cand_mv),
            .min_sad (min8x4[W8X4*i +: W8X4]),
            .best_mv (mv8x4[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N8X8; i++) begin : g_8x8
        sad_min_cell #(.SAD_W(W8X8)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD8x8[W8X8*i +: W8X8]),
            .mv      (cand_mv),
            .min_sad (min8x8[W8X8*i +: W8X8]),
            .best_mv (mv8x8[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N8X16; i++) begin : g_8x16
        sad_min_cell #(.SAD_W(W8X16)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD8x16[W8X16*i +: W8X16]),
            .mv      (cand_mv),
            .min_sad (min8x16[W8X16*i +: W8X16]),
            .best_mv (mv8x16[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N16X8; i++) begin : g_16x8
        sad_min_cell #(.SAD_W(W16X8)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD16x8[W16X8*i +: W16X8]),
            .mv      (cand_mv),
            .min_sad (min16x8[W16X8*i +: W16X8]),
            .best_mv (mv16x8[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N16X16; i++) begin : g_16x16
        sad_min_cell #(.SAD_W(W16X16)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD16x16[W16X16*i +: W16X16]),
            .mv      (cand_mv),
            .min_sad (min16x16[W16X16*i +: W16X16]),
            .best_mv (mv16x16[MV_W*i +: MV_W])
        );
    end

    for (genvar i = 0; i < N32X32; i++) begin : g_32x32
        sad_min_cell #(.SAD_W(W32X32)) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (search_start),
            .en      (cand_en),
            .sad     (SAD32x32[W32X32*i +: W32X32]),
            .mv      (cand_mv),
            .min_sad (min32x32[W32X32*i +: W32X32]),
            .best_mv (mv32x32[MV_W*i +: MV_W])
        );
    end

endmodule

// File: tb/tb_basic_layer_best_mv.sv
// Directed bench for basic_layer_best_mv: full-window sweeps with expected
// final results queued up front and checked when result_valid fires.
module tb_basic_layer_best_mv;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         search_start;
    logic         sad_valid;
    logic [415:0] SAD4x8, SAD8x4;
    logic [223:0] SAD8x8;
    logic [119:0] SAD8x16, SAD16x8;
    logic [63:0]  SAD16x16;
    logic [17:0]  SAD32x32;
    logic [4:0]   search_column_count;
    logic [6:0]   search_row_count;
    logic [415:0] min4x8, min8x4;
    logic [223:0] min8x8;
    logic [119:0] min8x16, min16x8;
    logic [63:0]  min16x16;
    logic [17:0]  min32x32;
    logic [383:0] mv4x8, mv8x4;
    logic [191:0] mv8x8;
    logic [95:0]  mv8x16, mv16x8;
    logic [47:0]  mv16x16;
    logic [11:0]  mv32x32;
    logic         busy, result_valid;

    typedef struct {
        logic [415:0] m4x8, m8x4;
        logic [223:0] m8x8;
        logic [119:0] m8x16, m16x8;
        logic [63:0]  m16x16;
        logic [17:0]  m32x32;
        logic [383:0] v4x8, v8x4;
        logic [191:0] v8x8;
        logic [95:0]  v8x16, v16x8;
        logic [47:0]  v16x16;
        logic [11:0]  v32x32;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   rv_count = 0;

    basic_layer_best_mv #(.LAST_COL(31), .LAST_ROW(63)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .search_start        (search_start),
        .sad_valid           (sad_valid),
        .SAD4x8              (SAD4x8),
        .SAD8x4              (SAD8x4),
        .SAD8x8              (SAD8x8),
        .SAD8x16             (SAD8x16),
        .SAD16x8             (SAD16x8),
        .SAD16x16            (SAD16x16),
        .SAD32x32            (SAD32x32),
        .search_column_count (search_column_count),
        .search_row_count    (search_row_count),
        .min4x8              (min4x8),
        .min8x4              (min8x4),
        .min8x8              (min8x8),
        .min8x16             (min8x16),
        .min16x8             (min16x8),
        .min16x16            (min16x16),
        .min32x32            (min32x32),
        .mv4x8               (mv4x8),
        .mv8x4               (mv8x4),
        .mv8x8               (mv8x8),
        .mv8x16              (mv8x16),
        .mv16x8              (mv16x8),
        .mv16x16             (mv16x16),
        .mv32x32             (mv32x32),
        .busy                (busy),
        .result_valid        (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected outcome where every partition settled at value v with mv 0
    function automatic exp_t uniform(input int v);
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.m4x8[13*i +: 13] = 13'(v);
            e.m8x4[13*i +: 13] = 13'(v);
        end
        for (int i = 0; i < 16; i++) e.m8x8[14*i +: 14] = 14'(v);
        for (int i = 0; i < 8; i++) begin
            e.m8x16[15*i +: 15] = 15'(v);
            e.m16x8[15*i +: 15] = 15'(v);
        end
        for (int i = 0; i < 4; i++) e.m16x16[16*i +: 16] = 16'(v);
        e.m32x32 = 18'(v);
        e.v4x8 = '0; e.v8x4 = '0; e.v8x8 = '0; e.v8x16 = '0;
        e.v16x8 = '0; e.v16x16 = '0; e.v32x32 = '0;
        return e;
    endfunction

    // Scoreboard: every result_valid pulse must match the oldest queued entry
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            exp_t e;
            rv_count++;
            chk("rv_expected", 416'(exp_q.size() > 0), 416'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("min4x8", min4x8, e.m4x8);     chk("mv4x8", mv4x8, e.v4x8);
                chk("min8x4", min8x4, e.m8x4);     chk("mv8x4", mv8x4, e.v8x4);
                chk("min8x8", min8x8, e.m8x8);     chk("mv8x8", mv8x8, e.v8x8);
                chk("min8x16", min8x16, e.m8x16);  chk("mv8x16", mv8x16, e.v8x16);
                chk("min16x8", min16x8, e.m16x8);  chk("mv16x8", mv16x8, e.v16x8);
                chk("min16x16", min16x16, e.m16x16); chk("mv16x16", mv16x16, e.v16x16);
                chk("min32x32", min32x32, e.m32x32); chk("mv32x32", mv32x32, e.v32x32);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 32; i++) begin
            SAD4x8[13*i +: 13] = 13'(v);
            SAD8x4[13*i +: 13] = 13'(v);
        end
        for (int i = 0; i < 16; i++) SAD8x8[14*i +: 14] = 14'(v);
        for (int i = 0; i < 8; i++) begin
            SAD8x16[15*i +: 15] = 15'(v);
            SAD16x8[15*i +: 15] = 15'(v);
        end
        for (int i = 0; i < 4; i++) SAD16x16[16*i +: 16] = 16'(v);
        SAD32x32 = 18'(v);
    endtask

    // mode 0: uniform v; 1: lone 8x8[0] winner; 2: 32x32 schedule, rest all-ones
    task automatic drive_cand(input int mode, input int v, input int col, input int row);
        case (mode)
            1: begin
                fill(200);
                if (col == 7 && row == 20) SAD8x8[13:0] = 14'd50;
            end
            2: begin
                fill(-1);
                SAD32x32 = 18'd1000;
                if (col == 0 && row == 0)  SAD32x32 = 18'd900;
                if (col == 10 && row == 2) SAD32x32 = 18'd50;
                if (col == 3 && row == 5)  SAD32x32 = 18'd10;
                if (col == 9 && row == 40) SAD32x32 = 18'd10;
            end
            default: fill(v);
        endcase
        search_column_count = 5'(col);
        search_row_count    = 7'(row);
        sad_valid           = 1'b1;
    endtask

    task automatic start_search();
        search_start = 1'b1;
        sad_valid    = 1'b0;
        tick();
        search_start = 1'b0;
    endtask

    task automatic sweep(input int mode, input int v, input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < 32; c++) begin
                drive_cand(mode, v, c, r);
                tick();
            end
        sad_valid = 1'b0;
    endtask

    task automatic wait_rv(input int target);
        for (int k = 0; k < 8; k++) begin
            if (rv_count >= target) break;
            tick();
        end
        tick();
        chk("rv_count", 416'(rv_count), 416'(target));
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; search_start = 1'b0; sad_valid = 1'b0;
        search_column_count = '0; search_row_count = '0;
        fill(0);
        #12;
        chk("rst_min4x8", min4x8, {416{1'b1}});
        chk("rst_min32x32", 416'(min32x32), 416'(18'h3FFFF));
        chk("rst_mv8x8", 416'(mv8x8), 416'(0));
        chk("rst_busy", 416'(busy), 416'(0));
        chk("rst_rv", 416'(result_valid), 416'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Uniform 100: first candidate wins every tie, mv stays 0
        start_search();
        chk("busy_search", 416'(busy), 416'(1));
        exp_q.push_back(uniform(100));
        sweep(0, 100, 64);
        wait_rv(1);
        chk("busy_idle", 416'(busy), 416'(0));

        // Lone 8x8[0] winner at (7,20)
        e = uniform(200);
        e.m8x8[13:0] = 14'd50;
        e.v8x8[11:0] = {7'd20, 5'd7};
        start_search();
        exp_q.push_back(e);
        sweep(1, 0, 64);
        wait_rv(2);

        // 32x32 descends to 10 at (3,5); equal 10 at (9,40) must not replace it
        e = uniform(-1);
        e.m32x32 = 18'd10;
        e.v32x32 = {7'd5, 5'd3};
        start_search();
        exp_q.push_back(e);
        sweep(2, 0, 64);
        wait_rv(3);

        // Abort at row 30, then a full uniform-77 sweep
        start_search();
        sweep(0, 100, 30);
        start_search();
        exp_q.push_back(uniform(77));
        sweep(0, 77, 64);
        wait_rv(4);

        // start + sad_valid together: the 0 candidate is discarded
        search_start = 1'b1;
        drive_cand(0, -1, 0, 0);
        SAD16x16 = '0;
        tick();
        search_start = 1'b0;
        drive_cand(0, -1, 1, 0);
        SAD16x16 = {4{16'd5}};
        tick();
        sad_valid = 1'b0;
        chk("coinc_min16x16", 416'(min16x16), 416'({4{16'd5}}));
        chk("coinc_mv16x16", 416'(mv16x16), 416'({4{12'd1}}));
        chk("coinc_min4x8", min4x8, {416{1'b1}});

        // Async reset in the middle of a search
        start_search();
        for (int c = 0; c < 3; c++) begin
            drive_cand(0, 3, c, 0);
            tick();
        end
        sad_valid = 1'b0;
        chk("pre_rst_min32x32", 416'(min32x32), 416'(18'd3));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_min32x32", 416'(min32x32), 416'(18'h3FFFF));
        chk("mid_rst_mv32x32", 416'(mv32x32), 416'(0));
        chk("mid_rst_min8x4", min8x4, {416{1'b1}});
        chk("mid_rst_busy", 416'(busy), 416'(0));
        chk("mid_rst_rv", 416'(result_valid), 416'(0));
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 29; c < 32; c++) begin
            drive_cand(0, 3, c, 63);
            tick();
        end
        sad_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("no_rv_after_rst", 416'(rv_count), 416'(4));
        chk("idle_busy", 416'(busy), 416'(0));
        chk("queue_drained", 416'(exp_q.size()), 416'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
